// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deserialises frames and holds raw_* high while the mapped keys are down.
// Optional build macro: PS2_GLITCH_FILTER_EN adds a counter filter on the synced ps2_clk.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       raw_left,
  output logic       raw_right,
  output logic       raw_down,
  output logic       raw_rotate,
  output logic       raw_drop,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

  logic [1:0]    clk_sync_reg, data_sync_reg;
  logic          clk_level, data_level, clk_filt, clk_prev_reg, fall;
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    shift_reg, byte_data_reg;
  logic          parity_reg, byte_valid_reg, frame_err_reg;
  logic [TW-1:0] timer_reg;
  state_t        state_reg, state_next;
  logic          key_ext, key_make, key_break;
  logic [4:0]    key_mask, keys_reg, keys_next;

  // Synchronisers reset high so releasing reset never looks like a falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  assign clk_level  = clk_sync_reg[1];
  assign data_level = data_sync_reg[1];

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic          filt_reg;
  logic [FW-1:0] filt_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
    end else if (clk_level == filt_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
      filt_reg     <= clk_level;
      filt_cnt_reg <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 1'b1;
    end
  end

  assign clk_filt = filt_reg;
`else
  assign clk_filt = clk_level;
`endif

  always_ff @(posedge clk) begin
    if (rst) clk_prev_reg <= 1'b1;
    else     clk_prev_reg <= clk_filt;
  end

  assign fall = clk_prev_reg & ~clk_filt;

  // Frame deserialiser with mid-frame inactivity timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      timer_reg      <= '0;
      byte_valid_reg <= 1'b0;
      byte_data_reg  <= '0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (fall) begin
        timer_reg <= '0;
        case (bit_cnt_reg)
          4'd0: begin
            if (!data_level) bit_cnt_reg   <= 4'd1;
            else             frame_err_reg <= 1'b1;
          end
          4'd9: begin
            parity_reg  <= data_level;
            bit_cnt_reg <= 4'd10;
          end
          4'd10: begin
            bit_cnt_reg <= '0;
            if (data_level && (^{parity_reg, shift_reg})) begin
              byte_valid_reg <= 1'b1;
              byte_data_reg  <= shift_reg;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end
          default: begin
            shift_reg   <= {data_level, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
          end
        endcase
      end else if (bit_cnt_reg != '0) begin
        if (timer_reg == TIMEOUT_LAST) begin
          timer_reg     <= '0;
          bit_cnt_reg   <= '0;
          frame_err_reg <= 1'b1;
        end else begin
          timer_reg <= timer_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // A bad frame drops any pending prefix
  always_comb begin
    state_next = state_reg;
    key_ext    = 1'b0;
    key_make   = 1'b0;
    key_break  = 1'b0;
    if (frame_err_reg) begin
      state_next = ST_IDLE;
    end else if (byte_valid_reg) begin
      case (state_reg)
        ST_IDLE: begin
          if (byte_data_reg == 8'hE0)      state_next = ST_EXT;
          else if (byte_data_reg == 8'hF0) state_next = ST_BRK;
          else                             key_make   = 1'b1;
        end
        ST_EXT: begin
          if (byte_data_reg == 8'hF0)      state_next = ST_EXT_BRK;
          else if (byte_data_reg == 8'hE0) state_next = ST_EXT;
          else begin
            key_ext    = 1'b1;
            key_make   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          key_break  = 1'b1;
          state_next = ST_IDLE;
        end
        default: begin
          key_ext    = 1'b1;
          key_break  = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Bit order: left, right, down, rotate, drop
  always_comb begin
    key_mask = 5'b00000;
    case ({key_ext, byte_data_reg})
      9'h16B:  key_mask = 5'b00001;
      9'h174:  key_mask = 5'b00010;
      9'h172:  key_mask = 5'b00100;
      9'h175:  key_mask = 5'b01000;
      9'h029:  key_mask = 5'b10000;
      default: key_mask = 5'b00000;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_key
      assign keys_next[gi] = (key_make & key_mask[gi]) |
                             (keys_reg[gi] & ~(key_break & key_mask[gi]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) keys_reg <= '0;
    else     keys_reg <= keys_next;
  end

  assign raw_left   = keys_reg[0];
  assign raw_right  = keys_reg[1];
  assign raw_down   = keys_reg[2];
  assign raw_rotate = keys_reg[3];
  assign raw_drop   = keys_reg[4];
  assign byte_valid = byte_valid_reg;
  assign byte_data  = byte_data_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frames driven bit by bit, expectations hand-computed.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_data;
  logic       raw_left, raw_right, raw_down, raw_rotate, raw_drop;
  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  ps2_key_decoder #(.TIMEOUT_CYCLES(500), .FILTER_LEN(8)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .raw_left(raw_left), .raw_right(raw_right), .raw_down(raw_down),
    .raw_rotate(raw_rotate), .raw_drop(raw_drop),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  wire [4:0] raw_all = {raw_drop, raw_rotate, raw_down, raw_right, raw_left};

  int n_cmp = 0;
  int n_mis = 0;

  // Monitor: counts pulses and records edge timing, sampled on the falling clk edge
  int         cyc = 0, bv_count = 0, err_count = 0;
  int         last_bv_cyc = 0, left_rise_cyc = 0, right_falls = 0, other_toggles = 0;
  logic [7:0] last_byte = 8'h00;
  logic       left_prev = 1'b0, right_prev = 1'b0;
  logic [3:0] other_prev = 4'h0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (byte_valid) begin
      bv_count    = bv_count + 1;
      last_byte   = byte_data;
      last_bv_cyc = cyc;
    end
    if (frame_err) err_count = err_count + 1;
    if (raw_left && !left_prev) left_rise_cyc = cyc;
    if (!raw_right && right_prev) right_falls = right_falls + 1;
    if ({raw_right, raw_down, raw_rotate, raw_drop} != other_prev) other_toggles = other_toggles + 1;
    left_prev  = raw_left;
    right_prev = raw_right;
    other_prev = {raw_right, raw_down, raw_rotate, raw_drop};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bits[0] is sent first; each bit: 10 cycles setup, 20 low, 10 high
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic       par;
    logic [10:0] frame;
    par   = (~^b) ^ bad_par;
    frame = {1'b1, par, b, 1'b0};
    send_bits(frame, 11);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  int b0, e0, o0, rf0;

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("reset_raw", {27'd0, raw_all}, 32'd0);
    check_eq("reset_bv_fe", {30'd0, byte_valid, frame_err}, 32'd0);
    check_eq("reset_byte", {24'd0, byte_data}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Extended Left make then break, with latency check
    b0 = bv_count; e0 = err_count; o0 = other_toggles;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    check_eq("t1_left_make", {31'd0, raw_left}, 32'd1);
    check_eq("t1_left_latency", left_rise_cyc, last_bv_cyc + 1);
    check_eq("t1_byte", {24'd0, last_byte}, 32'h6B);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    check_eq("t1_left_break", {31'd0, raw_left}, 32'd0);
    check_eq("t1_bv_count", bv_count - b0, 32'd5);
    check_eq("t1_other_quiet", other_toggles - o0, 32'd0);
    check_eq("t1_no_err", err_count - e0, 32'd0);

    // Space + Up together, then release Space only
    send_byte(8'h29, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    check_eq("t2_drop_rotate", {27'd0, raw_all}, 32'b11000);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    check_eq("t2_drop_released", {27'd0, raw_all}, 32'b01000);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check_eq("t2_all_clear", {27'd0, raw_all}, 32'd0);

    // Bad parity on 6B, then non-extended break
    b0 = bv_count; e0 = err_count;
    send_byte(8'h6B, 1'b1);
    check_eq("t3_parity_err", err_count - e0, 32'd1);
    check_eq("t3_no_bv", bv_count - b0, 32'd0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    check_eq("t3_raw_zero", {27'd0, raw_all}, 32'd0);
    check_eq("t3_bv_after", bv_count - b0, 32'd2);

    // Bad start bit: single clock pulse with data high
    b0 = bv_count; e0 = err_count;
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("t_start_err", err_count - e0, 32'd1);
    check_eq("t_start_no_bv", bv_count - b0, 32'd0);

    // Partial frame then timeout, then good E0 72
    e0 = err_count;
    send_bits(11'b110_1100_0000, 5);
    ps2_data = 1'b1;
    repeat (600) @(negedge clk);
    check_eq("t4_timeout_err", err_count - e0, 32'd1);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h72, 1'b0);
    check_eq("t4_down", {27'd0, raw_all}, 32'b00100);
    check_eq("t4_byte", {24'd0, last_byte}, 32'h72);
    check_eq("t4_single_err", err_count - e0, 32'd1);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h72, 1'b0);
    check_eq("t4_down_clear", {31'd0, raw_down}, 32'd0);

    // Keypad 4 (non-extended 6B) is unmapped
    b0 = bv_count;
    send_byte(8'h6B, 1'b0);
    check_eq("t5_bv", bv_count - b0, 32'd1);
    check_eq("t5_byte", {24'd0, last_byte}, 32'h6B);
    check_eq("t5_raw_zero", {27'd0, raw_all}, 32'd0);

    // Right held, typematic repeat, reset mid-frame, then fresh break
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    check_eq("t6_right", {31'd0, raw_right}, 32'd1);
    rf0 = right_falls;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    check_eq("t6_repeat_held", {31'd0, raw_right}, 32'd1);
    check_eq("t6_repeat_no_glitch", right_falls - rf0, 32'd0);
    send_bits({1'b1, 1'b0, 8'hE0, 1'b0}, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t6_rst_raw", {27'd0, raw_all}, 32'd0);
    check_eq("t6_rst_byte", {24'd0, byte_data}, 32'd0);
    check_eq("t6_rst_bv_fe", {30'd0, byte_valid, frame_err}, 32'd0);
    ps2_data = 1'b1;
    repeat (50) @(negedge clk);
    b0 = bv_count; e0 = err_count;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h74, 1'b0);
    check_eq("t6_bv_three", bv_count - b0, 32'd3);
    check_eq("t6_no_err", err_count - e0, 32'd0);
    check_eq("t6_right_clear", {31'd0, raw_right}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
